// File: rtl/lr_modexp.sv
// Left-to-right binary modular exponentiation: result = base^exponent mod modulus.
// A shared bit-serial interleaved multiplier (32 cycles) handles REDUCE, SQR and MUL.
module lr_modexp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, REDUCE, SQR, MUL, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] b_q, e_q, n_q, r_q, p_q;
  logic [IW-1:0]    k_q, i_q;

  logic             mul_last, bit_set, i_zero;
  logic [WIDTH-1:0] mul_a, mul_b;
  logic [WIDTH+1:0] n_ext, t0, t1, t2;

  assign mul_last = (k_q == '0);
  assign i_zero   = (i_q == '0);
  assign bit_set  = e_q[i_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = (modulus < WIDTH'(2)) ? DONE : REDUCE;
      REDUCE: if (mul_last) state_nxt = SQR;
      SQR:    if (mul_last) begin
                if (bit_set)     state_nxt = MUL;
                else if (i_zero) state_nxt = DONE;
                else             state_nxt = SQR;
              end
      MUL:    if (mul_last) state_nxt = i_zero ? DONE : SQR;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Multiplier operand select and one interleaved step; P < N and b < N keep T < 3N.
  always_comb begin
    mul_a = r_q;
    mul_b = r_q;
    case (state)
      REDUCE: begin mul_a = b_q; mul_b = WIDTH'(1); end
      MUL:    mul_b = b_q;
      default: ;
    endcase
    n_ext = {2'b00, n_q};
    t0 = {1'b0, p_q, 1'b0} + (mul_a[k_q] ? {2'b00, mul_b} : '0);
    t1 = (t0 >= n_ext) ? t0 - n_ext : t0;
    t2 = (t1 >= n_ext) ? t1 - n_ext : t1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      b_q    <= '0;
      e_q    <= '0;
      n_q    <= '0;
      r_q    <= '0;
      p_q    <= '0;
      k_q    <= '0;
      i_q    <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      busy <= (state_nxt != IDLE);
      case (state)
        IDLE: if (start) begin
          b_q <= base;
          e_q <= exponent;
          n_q <= modulus;
          r_q <= WIDTH'(1);
          p_q <= '0;
          k_q <= IW'(WIDTH-1);
          i_q <= IW'(WIDTH-1);
        end
        REDUCE, SQR, MUL: begin
          if (mul_last) begin
            p_q <= '0;
            k_q <= IW'(WIDTH-1);
            if (state == REDUCE) b_q <= t2[WIDTH-1:0];
            else                 r_q <= t2[WIDTH-1:0];
            if (((state == SQR && !bit_set) || state == MUL) && !i_zero)
              i_q <= i_q - 1'b1;
          end else begin
            p_q <= t2[WIDTH-1:0];
            k_q <= k_q - 1'b1;
          end
        end
        DONE: begin
          done   <= 1'b1;
          result <= (n_q < WIDTH'(2)) ? '0 : r_q;
        end
        default: ;
      endcase
    end
  end

endmodule
